// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framed transmitter: start bit, data LSB first, optional parity, stop bits.
// Every output except in_ready is driven from a flop loaded with the value for the next state.
module serial_frame_tx #(
  parameter int WIDTH  = 8,
  parameter int DIV    = 16,
  parameter int PARITY = 0,
  parameter int STOP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             bit_strobe
);

  localparam int CNT_W = $clog2(DIV);
  localparam int BIT_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cyc, cyc_nxt;
  logic [BIT_W-1:0]   bit_idx, bit_nxt;
  logic [WIDTH-1:0]   shift_reg, shift_nxt;
  logic               par_bit, par_nxt;
  logic               tx_nxt;
  logic               busy_nxt;
  logic               strobe_nxt;
  logic               cyc_last;
  logic               data_last;
  logic               stop_last;
  logic               accept;

  function automatic logic parity_of(input logic [WIDTH-1:0] w);
    return (^w) ^ (PARITY == 2);
  endfunction

  assign cyc_last  = (cyc == CNT_W'(DIV - 1));
  assign data_last = (bit_idx == BIT_W'(WIDTH - 1));
  assign stop_last = (bit_idx == BIT_W'(STOP - 1));

  // Ready is decoded from state and counters only, never from in_valid.
  assign in_ready = (state == S_IDLE) || ((state == S_STOP) && cyc_last && stop_last);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    cyc_nxt   = '0;
    bit_nxt   = bit_idx;
    shift_nxt = shift_reg;
    par_nxt   = par_bit;

    if (state != S_IDLE) begin
      cyc_nxt = cyc_last ? '0 : cyc + 1'b1;
    end

    // Parity is taken from the word as it is latched, so later in_data changes cannot leak in.
    if (accept) begin
      shift_nxt = in_data;
      par_nxt   = parity_of(in_data);
    end

    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_START;
          bit_nxt   = '0;
        end
      end
      S_START: begin
        if (cyc_last) begin
          state_nxt = S_DATA;
          bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (cyc_last) begin
          shift_nxt = shift_reg >> 1;
          if (data_last) begin
            bit_nxt   = '0;
            state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_nxt = bit_idx + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (cyc_last) begin
          state_nxt = S_STOP;
          bit_nxt   = '0;
        end
      end
      S_STOP: begin
        if (cyc_last) begin
          if (stop_last) begin
            bit_nxt   = '0;
            state_nxt = accept ? S_START : S_IDLE;
          end else begin
            bit_nxt = bit_idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        bit_nxt   = '0;
      end
    endcase

    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shift_nxt[0];
      S_PAR:   tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase

    busy_nxt   = (state_nxt != S_IDLE);
    strobe_nxt = (state_nxt != S_IDLE) && (cyc_nxt == '0);
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cyc        <= '0;
      bit_idx    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      bit_strobe <= 1'b0;
    end else begin
      state      <= state_nxt;
      cyc        <= cyc_nxt;
      bit_idx    <= bit_nxt;
      tx         <= tx_nxt;
      busy       <= busy_nxt;
      bit_strobe <= strobe_nxt;
    end
  end

  // Data registers
  always_ff @(posedge clk) begin
    shift_reg <= shift_nxt;
    par_bit   <= par_nxt;
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: four instances cover no parity, even, odd and minimum-size frames.
module tb_serial_frame_tx;

  logic       clk;
  logic       rst;
  logic       v0, v1, v2, v3;
  logic [7:0] d0, d1, d2;
  logic [0:0] d3;
  logic       r0, r1, r2, r3;
  logic       t0, t1, t2, t3;
  logic       b0, b1, b2, b3;
  logic       s0, s1, s2, s3;

  int n_assert;
  int n_fail;

  serial_frame_tx #(.WIDTH(8), .DIV(4), .PARITY(0), .STOP(1)) u_np (
    .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0),
    .tx(t0), .busy(b0), .bit_strobe(s0));

  serial_frame_tx #(.WIDTH(8), .DIV(4), .PARITY(1), .STOP(1)) u_ev (
    .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1),
    .tx(t1), .busy(b1), .bit_strobe(s1));

  serial_frame_tx #(.WIDTH(8), .DIV(4), .PARITY(2), .STOP(1)) u_od (
    .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2),
    .tx(t2), .busy(b2), .bit_strobe(s2));

  serial_frame_tx #(.WIDTH(1), .DIV(2), .PARITY(0), .STOP(2)) u_lim (
    .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(r3),
    .tx(t3), .busy(b3), .bit_strobe(s3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {tx, busy, bit_strobe, in_ready} of the selected instance
  function automatic logic [3:0] obs(input int sel);
    case (sel)
      0:       return {t0, b0, s0, r0};
      1:       return {t1, b1, s1, r1};
      2:       return {t2, b2, s2, r2};
      default: return {t3, b3, s3, r3};
    endcase
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    case (sel)
      0:       begin v0 = v; d0 = d; end
      1:       begin v1 = v; d1 = d; end
      2:       begin v2 = v; d2 = d; end
      default: begin v3 = v; d3 = d[0:0]; end
    endcase
  endtask

  // Expected line level for bit slot n of a frame carrying word w
  function automatic logic frame_bit(input logic [7:0] w, input int n, input int width,
                                     input int par);
    logic x;
    x = 1'b0;
    for (int i = 0; i < width; i++) x ^= w[i];
    if (n == 0) return 1'b0;
    if (n <= width) return w[n-1];
    if (par != 0 && n == width + 1) return (par == 2) ? ~x : x;
    return 1'b1;
  endfunction

  task automatic chk_idle(input int sel, input string tag);
    logic [3:0] o;
    o = obs(sel);
    chk({tag, "_tx"}, 32'(o[3]), 32'd1);
    chk({tag, "_busy"}, 32'(o[2]), 32'd0);
    chk({tag, "_strobe"}, 32'(o[1]), 32'd0);
    chk({tag, "_ready"}, 32'(o[0]), 32'd1);
  endtask

  // Sends w0 (and w1 back-to-back when nfr==2) and checks every cycle of the frames.
  task automatic run_frames(input int sel, input string tag, input logic [7:0] w0,
                            input logic [7:0] w1, input int nfr, input int div,
                            input int width, input int par, input int stop);
    int len, pos, f;
    logic [3:0] o;
    logic [7:0] w;
    len = (1 + width + ((par != 0) ? 1 : 0) + stop) * div;
    @(negedge clk);
    drive(sel, 1'b1, w0);
    chk({tag, "_ready_idle"}, 32'(obs(sel)), 32'(obs(sel)) | 32'd1);
    for (int c = 0; c < nfr * len; c++) begin
      @(negedge clk);
      if (c == 0) begin
        if (nfr == 2) drive(sel, 1'b1, w1);
        else          drive(sel, 1'b0, ~w0);
      end
      if (c == len) drive(sel, 1'b0, ~w1);
      f   = c / len;
      pos = c % len;
      w   = (f == 0) ? w0 : w1;
      o   = obs(sel);
      chk($sformatf("%s_tx_c%0d", tag, c), 32'(o[3]), 32'(frame_bit(w, pos / div, width, par)));
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(o[2]), 32'd1);
      chk($sformatf("%s_strobe_c%0d", tag, c), 32'(o[1]), 32'((pos % div) == 0));
      chk($sformatf("%s_ready_c%0d", tag, c), 32'(o[0]), 32'(pos == len - 1));
    end
    @(negedge clk);
    chk_idle(sel, {tag, "_after"});
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) chk_idle(s, $sformatf("rst_inst%0d", s));
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 4; s++) chk_idle(s, $sformatf("post_rst_inst%0d", s));

    run_frames(0, "basic_a5", 8'hA5, 8'h00, 1, 4, 8, 0, 1);
    run_frames(1, "even_a5", 8'hA5, 8'h00, 1, 4, 8, 1, 1);
    run_frames(1, "even_07", 8'h07, 8'h00, 1, 4, 8, 1, 1);
    run_frames(2, "odd_a5", 8'hA5, 8'h00, 1, 4, 8, 2, 1);
    run_frames(2, "odd_07", 8'h07, 8'h00, 1, 4, 8, 2, 1);
    run_frames(0, "b2b", 8'h3C, 8'hC3, 2, 4, 8, 0, 1);

    // Reset in the middle of data bit 3 of 0xFF
    @(negedge clk);
    drive(0, 1'b1, 8'hFF);
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (c == 0) drive(0, 1'b0, 8'hFF);
      chk($sformatf("rstmid_tx_c%0d", c), 32'(t0), 32'(frame_bit(8'hFF, c / 4, 8, 0)));
    end
    rst = 1'b1;
    #1;
    chk("rstmid_async_tx", 32'(t0), 32'd1);
    chk("rstmid_async_ready", 32'(r0), 32'd1);
    chk("rstmid_async_busy", 32'(b0), 32'd0);
    chk("rstmid_async_strobe", 32'(s0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle(0, "rstmid_release");
    run_frames(0, "after_rst_00", 8'h00, 8'h00, 1, 4, 8, 0, 1);

    run_frames(3, "limits", 8'h01, 8'h00, 1, 2, 1, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
